// File: rtl/stream_vision_pkg.sv
// Shared definitions for the stream vision blocks: pixel-beat field layout,
// bounding-box tracker FSM states and the empty-box coordinate sentinel.
package stream_vision_pkg;

    localparam int SOP_BIT = 25;
    localparam int EOP_BIT = 24;
    localparam int PIX_W   = 24;

    localparam int R_HI = 23;
    localparam int R_LO = 16;
    localparam int G_HI = 15;
    localparam int G_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;

    localparam int COORD_W = 11;
    localparam int COUNT_W = 20;

    // xmin/ymin start here so the first matching pixel always wins the min.
    localparam logic [COORD_W-1:0] COORD_NONE = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESULT = 2'd2
    } state_t;

    function automatic logic chan_in_range(input logic [7:0] v,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/bbox_pixel_match.sv
// Combinational three-channel inclusive range test of one RGB pixel
// against {R,G,B} lower and upper bounds.
module bbox_pixel_match
    import stream_vision_pkg::*;
(
    input  logic [PIX_W-1:0] i_pixel,
    input  logic [PIX_W-1:0] i_lo,
    input  logic [PIX_W-1:0] i_hi,
    output logic             o_match
);

    assign o_match = chan_in_range(i_pixel[R_HI:R_LO], i_lo[R_HI:R_LO], i_hi[R_HI:R_LO])
                   & chan_in_range(i_pixel[G_HI:G_LO], i_lo[G_HI:G_LO], i_hi[G_HI:G_LO])
                   & chan_in_range(i_pixel[B_HI:B_LO], i_lo[B_HI:B_LO], i_hi[B_HI:B_LO]);

endmodule

// File: rtl/stream_bbox_tracker.sv
// Per-frame bounding box of pixels inside an RGB threshold window.
// Define STREAM_BBOX_PIXCOUNT_EN to build the matching-pixel counter.
module stream_bbox_tracker
    import stream_vision_pkg::*;
#(
    parameter int DATA_WIDTH = 26,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready_out,
    input  logic [23:0]           thr_lo,
    input  logic [23:0]           thr_hi,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_found,
    output logic [10:0]           res_xmin,
    output logic [10:0]           res_xmax,
    output logic [10:0]           res_ymin,
    output logic [10:0]           res_ymax,
    output logic [19:0]           res_count,
    output logic                  err_sync
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

    state_t             r_state, w_state_next;
    logic [COORD_W-1:0] r_x, r_y, r_xmin, r_xmax, r_ymin, r_ymax;
    logic               r_found, r_err;
    logic [PIX_W-1:0]   r_thr_lo, r_thr_hi;

    logic               w_accept, w_sop, w_eop, w_start, w_pix, w_match;
    logic [PIX_W-1:0]   w_lo, w_hi;
    logic [COORD_W-1:0] w_x, w_y, w_base_xmin, w_base_xmax, w_base_ymin, w_base_ymax;
    logic               w_base_found;

    assign w_sop    = data_in[SOP_BIT];
    assign w_eop    = data_in[EOP_BIT];
    assign w_accept = valid_in & ready_out;
    assign w_start  = w_accept & w_sop;
    assign w_pix    = w_accept & ((r_state == ACTIVE) | w_sop);

    // A starting beat is judged against the live thresholds it will latch,
    // and against a freshly cleared box rather than the previous frame's.
    assign w_lo         = w_start ? thr_lo     : r_thr_lo;
    assign w_hi         = w_start ? thr_hi     : r_thr_hi;
    assign w_x          = w_start ? '0         : r_x;
    assign w_y          = w_start ? '0         : r_y;
    assign w_base_xmin  = w_start ? COORD_NONE : r_xmin;
    assign w_base_xmax  = w_start ? '0         : r_xmax;
    assign w_base_ymin  = w_start ? COORD_NONE : r_ymin;
    assign w_base_ymax  = w_start ? '0         : r_ymax;
    assign w_base_found = w_start ? 1'b0       : r_found;

    bbox_pixel_match u_match (
        .i_pixel (data_in[PIX_W-1:0]),
        .i_lo    (w_lo),
        .i_hi    (w_hi),
        .o_match (w_match)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        ready_out    = 1'b1;
        res_valid    = 1'b0;
        unique case (r_state)
            IDLE:    if (valid_in && w_sop) w_state_next = w_eop ? RESULT : ACTIVE;
            ACTIVE:  if (valid_in && w_eop) w_state_next = RESULT;
            RESULT: begin
                ready_out = 1'b0;
                res_valid = 1'b1;
                if (res_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_xmin   <= COORD_NONE;
            r_xmax   <= '0;
            r_ymin   <= COORD_NONE;
            r_ymax   <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
            r_thr_lo <= '0;
            r_thr_hi <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_thr_lo <= thr_lo;
                r_thr_hi <= thr_hi;
            end
            if (w_accept && ((r_state == IDLE && !w_sop) || (r_state == ACTIVE && w_sop)))
                r_err <= 1'b1;
            if (w_pix) begin
                r_x     <= (w_x == X_LAST) ? '0 : w_x + 1'b1;
                r_y     <= (w_x == X_LAST && w_y != Y_LAST) ? w_y + 1'b1 : w_y;
                r_found <= w_base_found | w_match;
                r_xmin  <= (w_match && w_x < w_base_xmin) ? w_x : w_base_xmin;
                r_xmax  <= (w_match && w_x > w_base_xmax) ? w_x : w_base_xmax;
                r_ymin  <= (w_match && w_y < w_base_ymin) ? w_y : w_base_ymin;
                r_ymax  <= (w_match && w_y > w_base_ymax) ? w_y : w_base_ymax;
            end
        end
    end

`ifdef STREAM_BBOX_PIXCOUNT_EN
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_base_count;

    assign w_base_count = w_start ? '0 : r_count;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_count <= '0;
        else if (w_pix)
            r_count <= (w_match && w_base_count != '1) ? w_base_count + 1'b1 : w_base_count;
    end

    assign res_count = r_count;
`else
    assign res_count = '0;
`endif

    assign res_found = r_found;
    assign res_xmin  = r_xmin;
    assign res_xmax  = r_xmax;
    assign res_ymin  = r_ymin;
    assign res_ymax  = r_ymax;
    assign err_sync  = r_err;

endmodule

// File: tb/tb_stream_bbox_tracker.sv
// Bench for stream_bbox_tracker on a 4x2 image: fixed frame table, corner
// sequences and random frames against an index-based reference model.
module tb_stream_bbox_tracker;

    localparam int W = 4;
    localparam int H = 2;
`ifdef STREAM_BBOX_PIXCOUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        res_ready = 1'b0;
    logic [25:0] data_in = '0;
    logic [23:0] thr_lo = '0;
    logic [23:0] thr_hi = '0;
    logic        ready_out, res_valid, res_found, err_sync;
    logic [10:0] res_xmin, res_xmax, res_ymin, res_ymax;
    logic [19:0] res_count;

    int total = 0;
    int bad   = 0;
    logic [23:0] fbuf [0:15];

    typedef struct packed {
        logic [23:0]      lo;
        logic [23:0]      hi;
        logic [3:0]       n;
        logic [7:0][23:0] px;
        logic             found;
        logic [10:0]      xmin;
        logic [10:0]      xmax;
        logic [10:0]      ymin;
        logic [10:0]      ymax;
        logic [19:0]      cnt;
    } vec_t;

    vec_t vecs [0:4];

    stream_bbox_tracker #(.DATA_WIDTH(26), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .thr_lo    (thr_lo),
        .thr_hi    (thr_hi),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_found (res_found),
        .res_xmin  (res_xmin),
        .res_xmax  (res_xmax),
        .res_ymin  (res_ymin),
        .res_ymax  (res_ymax),
        .res_count (res_count),
        .err_sync  (err_sync)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic f, input logic [10:0] xmn,
                                input logic [10:0] xmx, input logic [10:0] ymn,
                                input logic [10:0] ymx, input int cnt);
        check({tag, ".found"}, res_found, f);
        check({tag, ".xmin"},  res_xmin,  xmn);
        check({tag, ".xmax"},  res_xmax,  xmx);
        check({tag, ".ymin"},  res_ymin,  ymn);
        check({tag, ".ymax"},  res_ymax,  ymx);
        check({tag, ".count"}, res_count, CNT_EN ? cnt : 0);
    endtask

    // Reference: pixel i sits at column i%W, row i/W clamped to the last row.
    function automatic void model(input int n, input logic [23:0] lo, input logic [23:0] hi,
                                  output logic f, output logic [10:0] xmn, output logic [10:0] xmx,
                                  output logic [10:0] ymn, output logic [10:0] ymx, output int cnt);
        int x;
        int y;
        bit m;
        f = 1'b0; xmn = 11'h7FF; xmx = '0; ymn = 11'h7FF; ymx = '0; cnt = 0;
        for (int i = 0; i < n; i++) begin
            x = i % W;
            y = (i / W > H - 1) ? H - 1 : i / W;
            m = 1'b1;
            for (int c = 0; c < 3; c++)
                if (fbuf[i][8*c +: 8] < lo[8*c +: 8] || fbuf[i][8*c +: 8] > hi[8*c +: 8]) m = 1'b0;
            if (m) begin
                f = 1'b1;
                if (x < xmn) xmn = 11'(x);
                if (x > xmx) xmx = 11'(x);
                if (y < ymn) ymn = 11'(y);
                if (y > ymx) ymx = 11'(y);
                if (cnt < 20'hFFFFF) cnt++;
            end
        end
    endfunction

    task automatic beat(input logic sop, input logic eop, input logic [23:0] px);
        valid_in = 1'b1;
        data_in  = {sop, eop, px};
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    // Thresholds are scrambled after the first beat: only the latched copy may matter.
    task automatic send_frame(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) check({tag, ".pre_eop_valid"}, res_valid, 1'b0);
            beat(i == 0, i == n - 1, fbuf[i]);
            if (i == 0) begin
                thr_lo = 24'hFFFFFF;
                thr_hi = 24'h000000;
            end
        end
        check({tag, ".latency"}, res_valid, 1'b1);
    endtask

    task automatic release_result(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, ".idle_ready"}, ready_out, 1'b1);
        check({tag, ".valid_drop"}, res_valid, 1'b0);
    endtask

    initial begin
        logic [23:0] lo, hi;
        logic        ef;
        logic [10:0] exn, exx, eyn, eyx;
        int          ec, n;
        logic [7:0]  a, b;

        vecs[0] = '0;
        vecs[0].lo = 24'h000000; vecs[0].hi = 24'hFFFFFF; vecs[0].n = 4'd8;
        for (int i = 0; i < 8; i++) vecs[0].px[i] = 24'h123456;
        vecs[0].found = 1'b1; vecs[0].xmin = 11'd0; vecs[0].xmax = 11'd3;
        vecs[0].ymin = 11'd0; vecs[0].ymax = 11'd1; vecs[0].cnt = 20'd8;

        vecs[1] = '0;
        vecs[1].lo = 24'h800000; vecs[1].hi = 24'hFFFFFF; vecs[1].n = 4'd8;
        vecs[1].px[6] = 24'hFF0000;
        vecs[1].found = 1'b1; vecs[1].xmin = 11'd2; vecs[1].xmax = 11'd2;
        vecs[1].ymin = 11'd1; vecs[1].ymax = 11'd1; vecs[1].cnt = 20'd1;

        vecs[2] = '0;
        vecs[2].lo = 24'h800000; vecs[2].hi = 24'hFFFFFF; vecs[2].n = 4'd8;
        for (int i = 0; i < 8; i++) vecs[2].px[i] = 24'h7FFFFF;
        vecs[2].found = 1'b0; vecs[2].xmin = 11'h7FF; vecs[2].xmax = 11'd0;
        vecs[2].ymin = 11'h7FF; vecs[2].ymax = 11'd0; vecs[2].cnt = 20'd0;

        vecs[3] = '0;
        vecs[3].lo = 24'h101010; vecs[3].hi = 24'h101010; vecs[3].n = 4'd1;
        vecs[3].px[0] = 24'h101010;
        vecs[3].found = 1'b1; vecs[3].xmin = 11'd0; vecs[3].xmax = 11'd0;
        vecs[3].ymin = 11'd0; vecs[3].ymax = 11'd0; vecs[3].cnt = 20'd1;

        vecs[4] = '0;
        vecs[4].lo = 24'h101010; vecs[4].hi = 24'h202020; vecs[4].n = 4'd8;
        vecs[4].px[0] = 24'h0F2020; vecs[4].px[1] = 24'h202020; vecs[4].px[2] = 24'h212020;
        vecs[4].px[5] = 24'h101010; vecs[4].px[7] = 24'h151F20;
        vecs[4].found = 1'b1; vecs[4].xmin = 11'd1; vecs[4].xmax = 11'd3;
        vecs[4].ymin = 11'd0; vecs[4].ymax = 11'd1; vecs[4].cnt = 20'd3;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst.ready",     ready_out, 1'b1);
        check_result("rst", 1'b0, 11'h7FF, 11'd0, 11'h7FF, 11'd0, 0);
        check("rst.res_valid", res_valid, 1'b0);
        check("rst.err",       err_sync,  1'b0);

        // Fixed frame table
        for (int v = 0; v < 5; v++) begin
            thr_lo = vecs[v].lo;
            thr_hi = vecs[v].hi;
            for (int i = 0; i < 8; i++) fbuf[i] = vecs[v].px[i];
            send_frame($sformatf("vec%0d", v), int'(vecs[v].n));
            check_result($sformatf("vec%0d", v), vecs[v].found, vecs[v].xmin, vecs[v].xmax,
                         vecs[v].ymin, vecs[v].ymax, int'(vecs[v].cnt));
            release_result($sformatf("vec%0d", v));
        end
        check("table.err", err_sync, 1'b0);

        // Overlong frame: 11 beats, x keeps wrapping and y stays on the last row
        thr_lo = 24'h800000; thr_hi = 24'hFFFFFF;
        for (int i = 0; i < 11; i++) fbuf[i] = 24'h000000;
        fbuf[9] = 24'hFF0000; fbuf[10] = 24'hFF0000;
        send_frame("long", 11);
        check_result("long", 1'b1, 11'd1, 11'd2, 11'd1, 11'd1, 2);
        release_result("long");

        // Result held while the consumer stalls and the source keeps offering beats
        thr_lo = vecs[4].lo; thr_hi = vecs[4].hi;
        for (int i = 0; i < 8; i++) fbuf[i] = vecs[4].px[i];
        send_frame("hold", 8);
        valid_in = 1'b1;
        data_in  = {1'b0, 1'b0, 24'h202020};
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d.ready", k), ready_out, 1'b0);
            check($sformatf("hold%0d.valid", k), res_valid, 1'b1);
            check_result($sformatf("hold%0d", k), 1'b1, 11'd1, 11'd3, 11'd0, 11'd1, 3);
        end
        valid_in = 1'b0;
        release_result("hold");
        check("hold.err", err_sync, 1'b0);

        // Reset mid-frame discards the partial frame
        thr_lo = 24'h000000; thr_hi = 24'hFFFFFF;
        beat(1'b1, 1'b0, 24'h123456);
        beat(1'b0, 1'b0, 24'h123456);
        beat(1'b0, 1'b0, 24'h123456);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_result("midrst", 1'b0, 11'h7FF, 11'd0, 11'h7FF, 11'd0, 0);
        check("midrst.ready", ready_out, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("midrst.novalid%0d", k), res_valid, 1'b0);
        end
        thr_lo = vecs[1].lo; thr_hi = vecs[1].hi;
        for (int i = 0; i < 8; i++) fbuf[i] = vecs[1].px[i];
        send_frame("postrst", 8);
        check_result("postrst", 1'b1, 11'd2, 11'd2, 11'd1, 11'd1, 1);
        release_result("postrst");

        // Random frames against the reference model
        for (int f = 0; f < 25; f++) begin
            lo = '0; hi = '0;
            for (int c = 0; c < 3; c++) begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                lo[8*c +: 8] = (a < b) ? a : b;
                hi[8*c +: 8] = (a < b) ? b : a;
            end
            n = int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++)
                for (int c = 0; c < 3; c++)
                    fbuf[i][8*c +: 8] = ($urandom_range(0, 2) != 0)
                        ? 8'($urandom_range(int'(lo[8*c +: 8]), int'(hi[8*c +: 8])))
                        : 8'($urandom_range(0, 255));
            model(n, lo, hi, ef, exn, exx, eyn, eyx, ec);
            thr_lo = lo; thr_hi = hi;
            send_frame($sformatf("rnd%0d", f), n);
            check_result($sformatf("rnd%0d", f), ef, exn, exx, eyn, eyx, ec);
            release_result($sformatf("rnd%0d", f));
        end
        check("rnd.err", err_sync, 1'b0);

        // Stray beat in IDLE, then a restart in the middle of a frame
        thr_lo = 24'h800000; thr_hi = 24'hFFFFFF;
        beat(1'b0, 1'b0, 24'hFFFFFF);
        check("stray.err",   err_sync,  1'b1);
        check("stray.ready", ready_out, 1'b1);
        check("stray.valid", res_valid, 1'b0);
        beat(1'b1, 1'b0, 24'hFFFFFF);
        beat(1'b0, 1'b0, 24'hFFFFFF);
        beat(1'b0, 1'b0, 24'hFFFFFF);
        thr_lo = 24'h800000; thr_hi = 24'hFFFFFF;
        for (int i = 0; i < 8; i++) fbuf[i] = vecs[1].px[i];
        send_frame("restart", 8);
        check_result("restart", 1'b1, 11'd2, 11'd2, 11'd1, 11'd1, 1);
        release_result("restart");
        check("restart.err_sticky", err_sync, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
